// File: rtl/secure_gate_pkg.sv
// secure_gate_pkg: shared types, response encodings and helpers for the
// secure_gate APB security gate and its lock controller.
//   lock_state_t : LOCKED / UNLOCKED / LOCKOUT
//   xfer_state_t : T_IDLE / T_FWD / T_RESP / T_WAIT
//   RESP_OK/ERR  : value driven on pslverr
//   is_onehot    : true when exactly one bit of the (zero-extended) vector is set
package secure_gate_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_FWD  = 2'd1,
        T_RESP = 2'd2,
        T_WAIT = 2'd3
    } xfer_state_t;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/secure_gate_lockctl.sv
// secure_gate_lockctl: lock state machine of the secure gate.
// Tracks LOCKED/UNLOCKED/LOCKOUT, counts consecutive wrong keys, times the
// lockout period and, when SECURE_GATE_AUTO_RELOCK_EN is defined, relocks
// after RELOCK_CYC cycles without protected activity.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   key_hit       : a locally answered key access is being accepted this cycle
//   key_ok        : key write data equals the unlock key
//   prot_act      : some protected target is selected (upstream or downstream)
//   locked        : registered, 1 when state != UNLOCKED
//   lockout       : registered, 1 in LOCKOUT
//   key_local     : key access is answered by the gate (not forwarded)
//   key_err       : verdict for a local key access (1 = SLVERR)
//   expiring      : lockout ends on the coming edge; protected accesses must wait
module secure_gate_lockctl #(
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1024,
    parameter int RELOCK_CYC  = 65536
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_hit,
    input  logic key_ok,
    input  logic prot_act,
    output logic locked,
    output logic lockout,
    output logic key_local,
    output logic key_err,
    output logic expiring
);
    import secure_gate_pkg::*;

    localparam int TMR_W  = $clog2(LOCKOUT_CYC + 1);
    localparam int FCNT_W = 4;

    lock_state_t       state_r, state_nxt_s;
    logic [FCNT_W-1:0] fail_r, fail_nxt_s;
    logic [TMR_W-1:0]  timer_r, timer_nxt_s;
    logic              relock_fire_s;

    // Lockout expires on the edge that takes the timer from 1 to 0.
    assign expiring  = (state_r == LOCKOUT) && (timer_r == TMR_W'(1));
    // An UNLOCKED wrong key is an ordinary write and goes downstream.
    assign key_local = (state_r != UNLOCKED) || key_ok;
    assign key_err   = (state_r == LOCKOUT) || ((state_r == LOCKED) && !key_ok);

`ifdef SECURE_GATE_AUTO_RELOCK_EN
    localparam int RLK_W = $clog2(RELOCK_CYC + 1);
    logic [RLK_W-1:0] relock_r;

    assign relock_fire_s = (state_r == UNLOCKED) && !prot_act &&
                           (relock_r == RLK_W'(RELOCK_CYC - 1));

    // Idle counter: cycles spent UNLOCKED without protected activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_r <= '0;
        end else if ((state_r != UNLOCKED) || prot_act || relock_fire_s) begin
            relock_r <= '0;
        end else begin
            relock_r <= relock_r + RLK_W'(1);
        end
    end
`else
    logic unused_relock_s;
    assign relock_fire_s   = 1'b0;
    assign unused_relock_s = prot_act ^ (RELOCK_CYC == 0);
`endif

    // Next lock state, fail count and lockout timer.
    always_comb begin
        state_nxt_s = state_r;
        fail_nxt_s  = fail_r;
        timer_nxt_s = timer_r;
        case (state_r)
            LOCKED: begin
                if (key_hit && key_ok) begin
                    state_nxt_s = UNLOCKED;
                    fail_nxt_s  = '0;
                end else if (key_hit) begin
                    if (fail_r == FCNT_W'(MAX_FAIL - 1)) begin
                        state_nxt_s = LOCKOUT;
                        fail_nxt_s  = '0;
                        timer_nxt_s = TMR_W'(LOCKOUT_CYC);
                    end else begin
                        fail_nxt_s = fail_r + FCNT_W'(1);
                    end
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            UNLOCKED: begin
                if ((key_hit && key_ok) || relock_fire_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = UNLOCKED;
                end
            end
            LOCKOUT: begin
                if (timer_r == TMR_W'(1)) begin
                    state_nxt_s = LOCKED;
                    timer_nxt_s = '0;
                end else begin
                    timer_nxt_s = timer_r - TMR_W'(1);
                end
            end
            default: begin
                state_nxt_s = LOCKED;
                fail_nxt_s  = '0;
                timer_nxt_s = '0;
            end
        endcase
    end

    // Lock state registers; status outputs are decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= LOCKED;
            fail_r  <= '0;
            timer_r <= '0;
            locked  <= 1'b1;
            lockout <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fail_r  <= fail_nxt_s;
            timer_r <= timer_nxt_s;
            locked  <= (state_nxt_s != UNLOCKED);
            lockout <= (state_nxt_s == LOCKOUT);
        end
    end

endmodule

// File: rtl/secure_gate.sv
// secure_gate: APB security gate between one upstream APB master and
// NUM_TGT downstream APB targets selected one-hot.
// Targets flagged in PROT_MASK are forwarded only while UNLOCKED; a write of
// KEY_DATA to KEY_ADDR on a protected target toggles the lock. Illegal
// selects and blocked accesses are answered locally with SLVERR.
// Optional feature macro: SECURE_GATE_AUTO_RELOCK_EN (idle relock timer).
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   s_psel/penable/pwrite/pstrb/paddr/pwdata : upstream request
//   s_prdata/s_pready/s_pslverr         : upstream response (registered)
//   m_psel/penable/pwrite/pstrb/paddr/pwdata : downstream request (registered)
//   m_prdata/m_pready/m_pslverr         : per-target responses
//   locked, lockout                     : lock status
module secure_gate #(
    parameter int                   ADDR_W      = 20,
    parameter int                   DATA_W      = 16,
    parameter int                   NUM_TGT     = 2,
    parameter logic [NUM_TGT-1:0]   PROT_MASK   = 2'b10,
    parameter logic [ADDR_W-1:0]    KEY_ADDR    = 20'h00C1A,
    parameter logic [DATA_W-1:0]    KEY_DATA    = 16'hA007,
    parameter int                   MAX_FAIL    = 3,
    parameter int                   LOCKOUT_CYC = 1024,
    parameter int                   RELOCK_CYC  = 65536
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_TGT-1:0]        s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [DATA_W/8-1:0]       s_pstrb,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic [DATA_W-1:0]         s_pwdata,
    output logic [DATA_W-1:0]         s_prdata,
    output logic                      s_pready,
    output logic                      s_pslverr,
    output logic [NUM_TGT-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [DATA_W/8-1:0]       m_pstrb,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [NUM_TGT*DATA_W-1:0] m_prdata,
    input  logic [NUM_TGT-1:0]        m_pready,
    input  logic [NUM_TGT-1:0]        m_pslverr,
    output logic                      locked,
    output logic                      lockout
);
    import secure_gate_pkg::*;

    xfer_state_t          xfer_r, xfer_nxt_s;
    logic                 access_s, onehot_s, prot_sel_s, key_acc_s, key_ok_s, prot_act_s;
    logic                 key_hit_s, key_local_s, key_err_s, expiring_s;
    logic [DATA_W-1:0]    sel_rdata_s;
    logic                 sel_ready_s, sel_err_s;
    logic [NUM_TGT-1:0]   psel_nxt_s;
    logic                 penable_nxt_s, pwrite_nxt_s, pready_nxt_s, pslverr_nxt_s;
    logic [DATA_W/8-1:0]  pstrb_nxt_s;
    logic [ADDR_W-1:0]    paddr_nxt_s;
    logic [DATA_W-1:0]    pwdata_nxt_s, prdata_nxt_s;

    assign access_s   = s_penable && (s_psel != '0);
    assign onehot_s   = is_onehot(32'(s_psel));
    assign prot_sel_s = |(s_psel & PROT_MASK);
    assign key_acc_s  = prot_sel_s && s_pwrite && (s_paddr == KEY_ADDR);
    assign key_ok_s   = (s_pwdata == KEY_DATA);
    assign prot_act_s = prot_sel_s || (|(m_psel & PROT_MASK));

    secure_gate_lockctl #(
        .MAX_FAIL    (MAX_FAIL),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .RELOCK_CYC  (RELOCK_CYC)
    ) u_lockctl (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_hit   (key_hit_s),
        .key_ok    (key_ok_s),
        .prot_act  (prot_act_s),
        .locked    (locked),
        .lockout   (lockout),
        .key_local (key_local_s),
        .key_err   (key_err_s),
        .expiring  (expiring_s)
    );

    // Response of the target currently selected downstream; others are masked off.
    always_comb begin
        sel_rdata_s = '0;
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            sel_rdata_s = sel_rdata_s | (m_prdata[i*DATA_W +: DATA_W] & {DATA_W{m_psel[i]}});
            sel_ready_s = sel_ready_s | (m_pready[i] & m_psel[i]);
            sel_err_s   = sel_err_s | (m_pslverr[i] & m_psel[i]);
        end
    end

    // Transfer FSM next state and next values of all registered outputs.
    always_comb begin
        xfer_nxt_s    = xfer_r;
        psel_nxt_s    = m_psel;
        penable_nxt_s = m_penable;
        pwrite_nxt_s  = m_pwrite;
        pstrb_nxt_s   = m_pstrb;
        paddr_nxt_s   = m_paddr;
        pwdata_nxt_s  = m_pwdata;
        prdata_nxt_s  = '0;
        pready_nxt_s  = 1'b0;
        pslverr_nxt_s = RESP_OK;
        key_hit_s     = 1'b0;
        case (xfer_r)
            T_IDLE: begin
                if (!access_s) begin
                    xfer_nxt_s = T_IDLE;
                end else if (!onehot_s) begin
                    xfer_nxt_s    = T_RESP;
                    pready_nxt_s  = 1'b1;
                    pslverr_nxt_s = RESP_ERR;
                end else if (prot_sel_s && expiring_s) begin
                    // lockout ends this edge; evaluate the access once LOCKED
                    xfer_nxt_s = T_IDLE;
                end else if (key_acc_s && key_local_s) begin
                    key_hit_s     = 1'b1;
                    xfer_nxt_s    = T_RESP;
                    pready_nxt_s  = 1'b1;
                    pslverr_nxt_s = key_err_s ? RESP_ERR : RESP_OK;
                end else if (prot_sel_s && locked) begin
                    xfer_nxt_s    = T_RESP;
                    pready_nxt_s  = 1'b1;
                    pslverr_nxt_s = RESP_ERR;
                end else begin
                    // downstream gets its own setup cycle before the access phase
                    xfer_nxt_s    = T_FWD;
                    psel_nxt_s    = s_psel;
                    penable_nxt_s = 1'b0;
                    pwrite_nxt_s  = s_pwrite;
                    pstrb_nxt_s   = s_pstrb;
                    paddr_nxt_s   = s_paddr;
                    pwdata_nxt_s  = s_pwdata;
                end
            end
            T_FWD: begin
                if (s_psel == '0) begin
                    // upstream abandoned the transfer
                    xfer_nxt_s    = T_IDLE;
                    psel_nxt_s    = '0;
                    penable_nxt_s = 1'b0;
                end else if (m_penable && sel_ready_s) begin
                    xfer_nxt_s    = T_RESP;
                    psel_nxt_s    = '0;
                    penable_nxt_s = 1'b0;
                    pready_nxt_s  = 1'b1;
                    prdata_nxt_s  = sel_rdata_s;
                    pslverr_nxt_s = sel_err_s;
                end else begin
                    xfer_nxt_s    = T_FWD;
                    psel_nxt_s    = s_psel;
                    penable_nxt_s = s_penable;
                    pwrite_nxt_s  = s_pwrite;
                    pstrb_nxt_s   = s_pstrb;
                    paddr_nxt_s   = s_paddr;
                    pwdata_nxt_s  = s_pwdata;
                end
            end
            T_RESP: begin
                xfer_nxt_s = T_WAIT;
            end
            T_WAIT: begin
                if (!s_penable || (s_psel == '0)) begin
                    xfer_nxt_s = T_IDLE;
                end else begin
                    xfer_nxt_s = T_WAIT;
                end
            end
            default: begin
                xfer_nxt_s    = T_IDLE;
                psel_nxt_s    = '0;
                penable_nxt_s = 1'b0;
            end
        endcase
    end

    // Transfer state and all registered upstream/downstream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_r    <= T_IDLE;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_pstrb   <= '0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            s_prdata  <= '0;
            s_pready  <= 1'b0;
            s_pslverr <= 1'b0;
        end else begin
            xfer_r    <= xfer_nxt_s;
            m_psel    <= psel_nxt_s;
            m_penable <= penable_nxt_s;
            m_pwrite  <= pwrite_nxt_s;
            m_pstrb   <= pstrb_nxt_s;
            m_paddr   <= paddr_nxt_s;
            m_pwdata  <= pwdata_nxt_s;
            s_prdata  <= prdata_nxt_s;
            s_pready  <= pready_nxt_s;
            s_pslverr <= pslverr_nxt_s;
        end
    end

endmodule

// File: tb/tb_secure_gate.sv
// tb_secure_gate: self-checking bench for secure_gate. Upstream transfers push
// their expected response to a scoreboard; a monitor pops it on every s_pready.
// Two behavioural downstream targets with a small register file each.
module tb_secure_gate;

    localparam logic [19:0] KEY_A = 20'h00C1A;
    localparam logic [15:0] KEY_D = 16'hA007;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_psel;
    logic        s_penable, s_pwrite;
    logic [1:0]  s_pstrb;
    logic [19:0] s_paddr;
    logic [15:0] s_pwdata, s_prdata;
    logic        s_pready, s_pslverr;
    logic [1:0]  m_psel;
    logic        m_penable, m_pwrite;
    logic [1:0]  m_pstrb;
    logic [19:0] m_paddr;
    logic [15:0] m_pwdata;
    logic [31:0] m_prdata;
    logic [1:0]  m_pready, m_pslverr;
    logic        locked, lockout;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [16:0] exp_q[$];
    string       tag_q[$];
    logic [16:0] mon_e;
    string       mon_t;
    int          mpsel_cnt = 0;
    logic [1:0]  last_wr_sel = 2'b00;
    logic [15:0] last_wr_data = 16'h0000;
    int          tgt_waits;
    logic [15:0] tmem [2][16];
    int          wcnt [2];
    int          n0;
    int          n;

    always #5 clk = ~clk;

    secure_gate #(.RELOCK_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_pstrb(s_pstrb),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pstrb(m_pstrb),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .locked(locked), .lockout(lockout)
    );

    function automatic logic [15:0] init_word(input int t, input int a);
        if (t == 0 && a == 0) return 16'h1234;
        return {4'(t), 4'(a), 8'hC3};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream targets: tgt_waits+1 wait states, error on address low byte EE.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pready  <= 2'b00;
            m_pslverr <= 2'b00;
            m_prdata  <= 32'h0;
            for (int t = 0; t < 2; t++) begin
                wcnt[t] <= 0;
                for (int a = 0; a < 16; a++) tmem[t][a] <= init_word(t, a);
            end
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (m_psel[t] && m_penable && !m_pready[t]) begin
                    if (wcnt[t] >= tgt_waits) begin
                        m_pready[t]  <= 1'b1;
                        m_pslverr[t] <= (m_paddr[7:0] == 8'hEE);
                        wcnt[t]      <= 0;
                        if (m_pwrite) begin
                            tmem[t][m_paddr[3:0]] <= m_pwdata;
                            m_prdata[t*16 +: 16]  <= 16'h0000;
                        end else begin
                            m_prdata[t*16 +: 16]  <= tmem[t][m_paddr[3:0]];
                        end
                    end else begin
                        wcnt[t] <= wcnt[t] + 1;
                    end
                end else begin
                    m_pready[t]  <= 1'b0;
                    m_pslverr[t] <= 1'b0;
                    wcnt[t]      <= 0;
                end
            end
        end
    end

    // Response monitor: each s_pready pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && s_pready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_pready", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                check_eq({mon_t, "_rdata"}, 32'(s_prdata), 32'(mon_e[15:0]));
                check_eq({mon_t, "_err"}, 32'(s_pslverr), 32'(mon_e[16]));
            end
        end
        if (m_psel != 2'b00) mpsel_cnt++;
        if (m_psel != 2'b00 && m_penable && m_pwrite) begin
            last_wr_sel  = m_psel;
            last_wr_data = m_pwdata;
        end
    end

    task automatic apb_xfer(input string tag, input logic [1:0] sel, input logic wr,
                            input logic [19:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rdata, input logic exp_err);
        logic done;
        int   cyc;
        exp_q.push_back({exp_err, exp_rdata});
        tag_q.push_back(tag);
        @(negedge clk);
        s_psel = sel; s_pwrite = wr; s_paddr = addr; s_pwdata = wdata;
        s_pstrb = 2'b11; s_penable = 1'b0;
        @(negedge clk);
        s_penable = 1'b1;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            done = s_pready;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        s_psel = 2'b00; s_penable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; s_psel = 2'b00; s_penable = 1'b0; s_pwrite = 1'b0;
        s_pstrb = 2'b00; s_paddr = 20'h0; s_pwdata = 16'h0; tgt_waits = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_m_psel", 32'(m_psel), 32'd0);
        check_eq("rst_m_penable", 32'(m_penable), 32'd0);
        check_eq("rst_s_pready", 32'(s_pready), 32'd0);
        check_eq("rst_s_pslverr", 32'(s_pslverr), 32'd0);
        check_eq("rst_s_prdata", 32'(s_prdata), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd1);
        check_eq("rst_lockout", 32'(lockout), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // unprotected target forwards while LOCKED
        n0 = mpsel_cnt;
        apb_xfer("rd_t0", 2'b01, 1'b0, 20'h00010, 16'h0, 16'h1234, 1'b0);
        check_eq("rd_t0_fwd", 32'(mpsel_cnt > n0), 32'd1);

        // protected target blocked, then unlocked by key
        n0 = mpsel_cnt;
        apb_xfer("rd_t1_locked", 2'b10, 1'b0, 20'h00020, 16'h0, 16'h0000, 1'b1);
        check_eq("rd_t1_no_fwd", 32'(mpsel_cnt), 32'(n0));
        apb_xfer("key_unlock", 2'b10, 1'b1, KEY_A, KEY_D, 16'h0000, 1'b0);
        check_eq("key_no_fwd", 32'(mpsel_cnt), 32'(n0));
        check_eq("unlocked", 32'(locked), 32'd0);

        // forwarded writes/reads while UNLOCKED
        apb_xfer("wr_t1", 2'b10, 1'b1, 20'h00100, 16'h5555, 16'h0000, 1'b0);
        check_eq("wr_t1_sel", 32'(last_wr_sel), 32'h2);
        check_eq("wr_t1_data", 32'(last_wr_data), 32'h5555);
        apb_xfer("rd_t1", 2'b10, 1'b0, 20'h00100, 16'h0, 16'h5555, 1'b0);
        apb_xfer("wr_t0_slverr", 2'b01, 1'b1, 20'h000EE, 16'h7777, 16'h0000, 1'b1);
        apb_xfer("wrongkey_fwd", 2'b10, 1'b1, KEY_A, 16'h1111, 16'h0000, 1'b0);
        check_eq("wrongkey_fwd_data", 32'(last_wr_data), 32'h1111);
        check_eq("wrongkey_still_unlocked", 32'(locked), 32'd0);

        // reset in the middle of a forwarded transfer
        tgt_waits = 8;
        @(negedge clk);
        s_psel = 2'b01; s_pwrite = 1'b0; s_paddr = 20'h00010; s_penable = 1'b0;
        @(negedge clk);
        s_penable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("fwd_psel_before_rst", 32'(m_psel), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_m_psel", 32'(m_psel), 32'd0);
        check_eq("midrst_m_penable", 32'(m_penable), 32'd0);
        check_eq("midrst_m_paddr", 32'(m_paddr), 32'd0);
        check_eq("midrst_s_pready", 32'(s_pready), 32'd0);
        check_eq("midrst_locked", 32'(locked), 32'd1);
        s_psel = 2'b00; s_penable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tgt_waits = 1;
        repeat (2) @(negedge clk);

        // wrong keys into lockout
        apb_xfer("badkey1", 2'b10, 1'b1, KEY_A, 16'h0000, 16'h0000, 1'b1);
        apb_xfer("badkey2", 2'b10, 1'b1, KEY_A, 16'h0000, 16'h0000, 1'b1);
        check_eq("no_lockout_2", 32'(lockout), 32'd0);
        apb_xfer("badkey3", 2'b10, 1'b1, KEY_A, 16'h0000, 16'h0000, 1'b1);
        check_eq("lockout_3", 32'(lockout), 32'd1);
        apb_xfer("key_in_lockout", 2'b10, 1'b1, KEY_A, KEY_D, 16'h0000, 1'b1);
        check_eq("locked_in_lockout", 32'(locked), 32'd1);
        apb_xfer("rd_t0_lockout", 2'b01, 1'b0, 20'h00010, 16'h0, 16'h1234, 1'b0);
        repeat (900) @(negedge clk);
        check_eq("lockout_hold", 32'(lockout), 32'd1);
        n = 0;
        while (lockout && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("lockout_expired", 32'(lockout), 32'd0);
        check_eq("locked_after_lockout", 32'(locked), 32'd1);
        apb_xfer("key_after_lockout", 2'b10, 1'b1, KEY_A, KEY_D, 16'h0000, 1'b0);
        check_eq("unlocked_after_lockout", 32'(locked), 32'd0);

        // illegal multi-hot select
        n0 = mpsel_cnt;
        apb_xfer("psel_11", 2'b11, 1'b0, 20'h00010, 16'h0, 16'h0000, 1'b1);
        check_eq("psel_11_no_fwd", 32'(mpsel_cnt), 32'(n0));

        // idle behaviour while UNLOCKED
        check_eq("idle_start_unlocked", 32'(locked), 32'd0);
        repeat (20) @(negedge clk);
`ifdef SECURE_GATE_AUTO_RELOCK_EN
        check_eq("auto_relock", 32'(locked), 32'd1);
`else
        check_eq("no_auto_relock", 32'(locked), 32'd0);
        apb_xfer("key_lock", 2'b10, 1'b1, KEY_A, KEY_D, 16'h0000, 1'b0);
        check_eq("relocked_by_key", 32'(locked), 32'd1);
`endif

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/secure_gate.md
Name: secure_gate

Overview:
- Parametrised APB security gate between the SPI-slave APB bridge (upstream master) and NUM_TGT downstream APB targets. Successor to the two-target lock FSM.
- Generalised in:
  - target count;
  - per-target protection mask;
  - configurable unlock key.
- Adds failed-key counting with timed lockout, and explicit error responses for illegal selects.

Parameters:
ADDR_W, 20, APB address width
DATA_W, 16, APB data width (multiple of 8)
NUM_TGT, 2, number of downstream targets (one-hot select)
PROT_MASK, 2'b10, bit i=1: target i is forwarded only while UNLOCKED
KEY_ADDR, 20'h00C1A, address of the key register (decoded on any protected target)
KEY_DATA, 16'hA007, unlock/lock key value
MAX_FAIL, 3, consecutive wrong keys that trigger LOCKOUT (1..15)
LOCKOUT_CYC, 1024, LOCKOUT duration in clk cycles (>=2)
RELOCK_CYC, 65536, idle relock timeout (used only with SECURE_GATE_AUTO_RELOCK_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_psel  in  NUM_TGT  upstream one-hot select
s_penable, s_pwrite  in  1  upstream APB control
s_pstrb  in  DATA_W/8  upstream strobes
s_paddr  in  ADDR_W  upstream address
s_pwdata  in  DATA_W  upstream write data
s_prdata  out  DATA_W  upstream read data
s_pready, s_pslverr  out  1  upstream response
m_psel  out  NUM_TGT  downstream selects
m_penable, m_pwrite  out  1  downstream control
m_pstrb  out  DATA_W/8  downstream strobes
m_paddr  out  ADDR_W  downstream address
m_pwdata  out  DATA_W  downstream write data
m_prdata  in  NUM_TGT*DATA_W  packed target read data, target i at [i*DATA_W +: DATA_W]
m_pready, m_pslverr  in  NUM_TGT  per-target response
locked  out  1  1 when state != UNLOCKED
lockout  out  1  1 in LOCKOUT

Behaviour:
- Reset: all m_* = 0, s_prdata = 0, s_pready = 0, s_pslverr = 0; lock state LOCKED, fail count 0, timers 0. Reset mid-transfer aborts it with no response.
- Lock FSM (states LOCKED, UNLOCKED, LOCKOUT):
  - Key access = access phase (s_penable=1) with target i protected, s_paddr==KEY_ADDR and s_pwrite=1. Key accesses are never forwarded.
  - LOCKED, key data==KEY_DATA: go to UNLOCKED, fail count cleared, response OK.
  - LOCKED, wrong data: fail count +1, response SLVERR. If count reaches MAX_FAIL, go to LOCKOUT with timer=LOCKOUT_CYC and count cleared.
  - UNLOCKED, key data==KEY_DATA: go to LOCKED, response OK. Wrong data: forwarded as a normal write.
  - LOCKOUT: every protected access, including a correct key, gets SLVERR. Timer decrements each cycle; at 0 go to LOCKED.
  - Lock state changes on the same edge that issues s_pready.
- Transfer FSM (states T_IDLE, T_FWD, T_RESP, T_WAIT):
  - T_IDLE, s_psel not one-hot and nonzero, at access phase: go to T_RESP with SLVERR.
  - T_IDLE, local response (key access or blocked protected target), at access phase: go to T_RESP.
  - T_IDLE, s_psel one-hot and forwardable: register all s_* onto m_* (1-cycle latency) and go to T_FWD.
  - T_FWD: m_* track s_*. When the selected m_pready=1, capture m_prdata/m_pslverr of that target, drop m_psel/m_penable next edge, and go to T_RESP.
  - T_RESP: s_pready=1 for exactly one cycle with captured s_prdata/s_pslverr (s_prdata=0 for local responses). Go to T_WAIT.
  - T_WAIT: hold until s_penable=0 or s_psel=0, then go to T_IDLE. No duplicate responses.
- Unprotected targets forward in every lock state.
- m_pready of unselected targets is ignored.
- Simultaneous LOCKOUT expiry and an incoming key access: the expiry wins; the key is evaluated next cycle.

Optional Feature:
SECURE_GATE_AUTO_RELOCK_EN:
- Defined: in UNLOCKED, a counter increments each cycle without a protected access and resets on any protected access. At RELOCK_CYC it forces LOCKED. A coincident in-flight transfer completes normally.
- Undefined: counter absent; UNLOCKED persists until a key write or reset.

Decomposition:
- secure_gate_pkg: lock-state enum, transfer-state enum, RESP_OK/RESP_ERR constants, function is_onehot.
- Sub-module secure_gate_lockctl: lock FSM, fail counter, lockout timer, optional relock timer; outputs locked/lockout and key verdict.

Test Plan:
- LOCKED; read target 0 (unprotected) at 0x00010, target returns 16'h1234 after 2 wait states -> s_prdata=16'h1234, s_pslverr=0, single s_pready pulse.
- LOCKED; read target 1 -> m_psel stays 0, s_pslverr=1. Then write 16'hA007 to 0x00C1A via target 1 -> s_pslverr=0, locked=0.
- UNLOCKED; target 1 write 16'h5555 to 0x00100 -> m_psel=2'b10, m_pwdata=16'h5555 forwarded. Then key write -> locked=1.
- Three wrong keys (16'h0000) -> lockout=1. Correct key during lockout -> SLVERR. After 1024 cycles lockout=0; correct key then unlocks.
- s_psel=2'b11 -> SLVERR, no m_psel asserted. Reset_n pulsed during T_FWD -> all m_* = 0 immediately.
- SECURE_GATE_AUTO_RELOCK_EN with RELOCK_CYC=16: unlock, idle 16 cycles -> locked=1.
